// File: rtl/register_universal.sv
// register_universal
// WIDTH-bit universal register: clear, preset, parallel load, shift, rotate
// and up/down count, with a separately registered complement output.
// Serial and terminal outputs are combinational so that several instances
// can be chained into wider shift registers or counters.

module register_universal #(
    parameter int unsigned          WIDTH        = 4,
    parameter logic [WIDTH-1:0]     PRESET_VALUE = {WIDTH{1'b1}}
) (
    input  logic             clockpulse,
    input  logic             clear,
    input  logic             preset,
    input  logic             enable,
    input  logic [2:0]       mode,
    input  logic [WIDTH-1:0] data,
    input  logic             serial_in_left,
    input  logic             serial_in_right,
    output logic [WIDTH-1:0] signal_q,
    output logic [WIDTH-1:0] signal_q_,
    output logic             serial_out,
    output logic             terminal
);

    // Operation select encoding
    localparam logic [2:0] MODE_HOLD   = 3'b000;
    localparam logic [2:0] MODE_LOAD   = 3'b001;
    localparam logic [2:0] MODE_SHL    = 3'b010;
    localparam logic [2:0] MODE_SHR    = 3'b011;
    localparam logic [2:0] MODE_ROL    = 3'b100;
    localparam logic [2:0] MODE_ROR    = 3'b101;
    localparam logic [2:0] MODE_CNT_UP = 3'b110;
    localparam logic [2:0] MODE_CNT_DN = 3'b111;

    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] state_q;
    logic [WIDTH-1:0] state_d;
    logic [WIDTH-1:0] comp_q;
    logic [WIDTH-1:0] comp_d;

    logic             count_full;
    logic             count_empty;

    assign count_full  = &state_q;
    assign count_empty = ~|state_q;

    // Next-state selection for preset / enable / mode (clear handled at the flop)
    always_comb begin
        state_d = state_q;
        if (preset) begin
            state_d = PRESET_VALUE;
        end else if (enable) begin
            case (mode)
                MODE_HOLD:   state_d = state_q;
                MODE_LOAD:   state_d = data;
                MODE_SHL:    state_d = {state_q[WIDTH-2:0], serial_in_right};
                MODE_SHR:    state_d = {serial_in_left, state_q[WIDTH-1:1]};
                MODE_ROL:    state_d = {state_q[WIDTH-2:0], state_q[WIDTH-1]};
                MODE_ROR:    state_d = {state_q[0], state_q[WIDTH-1:1]};
                MODE_CNT_UP: state_d = state_q + ONE;
                MODE_CNT_DN: state_d = state_q - ONE;
                default:     state_d = state_q;
            endcase
        end
        // The complement is computed from the next state and stored in its
        // own register, so signal_q_ never depends combinationally on signal_q.
        comp_d = ~state_d;
    end

    // State and complement registers; clear overrides everything else
    always_ff @(posedge clockpulse) begin
        if (clear) begin
            state_q <= '0;
            comp_q  <= '1;
        end else begin
            state_q <= state_d;
            comp_q  <= comp_d;
        end
    end

    // Bit leaving the register for the current shift/rotate direction
    always_comb begin
        serial_out = 1'b0;
        case (mode)
            MODE_SHL, MODE_ROL: serial_out = state_q[WIDTH-1];
            MODE_SHR, MODE_ROR: serial_out = state_q[0];
            default:            serial_out = 1'b0;
        endcase
    end

    // Carry/borrow out: asserted only when this edge will actually wrap
    always_comb begin
        terminal = 1'b0;
        if (enable && !clear && !preset) begin
            if (mode == MODE_CNT_UP) begin
                terminal = count_full;
            end else if (mode == MODE_CNT_DN) begin
                terminal = count_empty;
            end
        end
    end

    assign signal_q  = state_q;
    assign signal_q_ = comp_q;

endmodule
